regime_scheduler: RTL and testbench

- Front-end sequencer for the timer/counter control path. It shares that controller between three requesters: an ELIST countdown, a CNT run and an UPDATE load.
- Arbitrates the requests round-robin and drives the controller's on[1:0] and start inputs. Watches regime and active to detect acceptance and completion.
- Reports per-requester completion and a sticky watchdog error.
- Sits between the button/command logic and the control path, whose ports are re-wired through this block.

---
 rtl/regime_pkg.sv | 28 ++
 rtl/rr_arb3.sv | 39 +++
 rtl/regime_scheduler.sv | 178 +++++++++++++++++
 tb/tb_regime_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regime_pkg.sv
// Shared codes, scheduler states and helpers for the regime scheduler.
package regime_pkg;

    localparam logic [1:0] CODE_OFF    = 2'd0;
    localparam logic [1:0] CODE_ELIST  = 2'd1;
    localparam logic [1:0] CODE_CNT    = 2'd2;
    localparam logic [1:0] CODE_UPDATE = 2'd3;

    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACCEPT,
        S_DRAIN
    } sched_state_t;

    // Index successor modulo 3 (requester order 0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Requester i drives regime code i+1.
    function automatic logic [1:0] code_of(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter; the pointer moves past the winner on advance.
module rr_arb3
    import regime_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       advance,
    output logic [2:0] win_oh,
    output logic [1:0] win_idx
);

    logic [1:0] ptr;
    logic [1:0] c0, c1, c2;

    assign c0 = ptr;
    assign c1 = rr_next(c0);
    assign c2 = rr_next(c1);

    always_comb begin
        win_idx = c2;
        if (req[c0]) begin
            win_idx = c0;
        end else if (req[c1]) begin
            win_idx = c1;
        end
    end

    assign win_oh = (|req) ? (3'b001 << win_idx) : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (advance && (|req)) begin
            ptr <= rr_next(win_idx);
        end
    end

endmodule

// File: rtl/regime_scheduler.sv
// Shares the timer/counter controller between ELIST, CNT and UPDATE requesters,
// sequencing on/start against regime/active with a watchdog on every wait.
module regime_scheduler
    import regime_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [CNT_W-1:0] cnt_len,
    input  logic             err_clr,
    input  logic [1:0]       regime,
    input  logic             active,
    output logic [1:0]       on,
    output logic             start,
    output logic [2:0]       gnt,
    output logic [2:0]       done,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    sched_state_t state, state_d;

    logic [1:0]       idx, idx_d;
    logic [1:0]       cur_code;
    logic [CNT_W-1:0] len, len_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WD_W-1:0]  wdog;
    logic             wd_dec;
    logic             advance;
    logic [2:0]       win_oh;
    logic [1:0]       win_idx;

    logic [1:0] on_d;
    logic       start_d;
    logic [2:0] gnt_d;
    logic [2:0] done_d;
    logic       err_d;
    logic [1:0] err_code_d;

    assign cur_code = code_of(idx);

    rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        len_d      = len;
        cnt_d      = cnt;
        on_d       = CODE_OFF;
        start_d    = 1'b0;
        gnt_d      = gnt;
        done_d     = 3'b000;
        err_d      = err_clr ? 1'b0 : err;
        err_code_d = err_clr ? CODE_OFF : err_code;
        advance    = 1'b0;
        wd_dec     = 1'b0;

        case (state)
            S_IDLE: begin
                if ((|req) && (regime == CODE_OFF)) begin
                    state_d = S_ISSUE;
                    advance = 1'b1;
                    idx_d   = win_idx;
                    gnt_d   = win_oh;
                    on_d    = code_of(win_idx);
                    len_d   = (cnt_len == '0) ? CNT_W'(1) : cnt_len;
                end
            end
            S_ISSUE: begin
                wd_dec = 1'b1;
                on_d   = cur_code;
                if (regime == cur_code) begin
                    state_d = S_ACCEPT;
                    on_d    = CODE_OFF;
                    start_d = (cur_code != CODE_UPDATE);
                    cnt_d   = len;
                end
            end
            S_ACCEPT: begin
                case (cur_code)
                    CODE_ELIST: begin
                        wd_dec = 1'b1;
                        if (active) begin
                            state_d = S_DRAIN;
                        end else begin
                            start_d = 1'b1;
                        end
                    end
                    CODE_CNT: begin
                        // cnt holds the remaining high cycles including the current one.
                        if (cnt <= CNT_W'(1)) begin
                            state_d = S_DRAIN;
                        end else begin
                            start_d = 1'b1;
                            cnt_d   = cnt - CNT_W'(1);
                        end
                    end
                    default: state_d = S_DRAIN;
                endcase
            end
            S_DRAIN: begin
                wd_dec = 1'b1;
                if (regime == CODE_OFF) begin
                    state_d = S_IDLE;
                    done_d  = gnt;
                    gnt_d   = 3'b000;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Expiry overrides everything, including a same-cycle err_clr.
        if (wd_dec && (state_d == state) && (wdog == '0)) begin
            state_d    = S_IDLE;
            on_d       = CODE_OFF;
            start_d    = 1'b0;
            gnt_d      = 3'b000;
            done_d     = 3'b000;
            err_d      = 1'b1;
            err_code_d = cur_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= 2'd0;
            len      <= '0;
            cnt      <= '0;
            wdog     <= '0;
            on       <= CODE_OFF;
            start    <= 1'b0;
            gnt      <= 3'b000;
            done     <= 3'b000;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_code <= CODE_OFF;
        end else begin
            idx      <= idx_d;
            len      <= len_d;
            cnt      <= cnt_d;
            on       <= on_d;
            start    <= start_d;
            gnt      <= gnt_d;
            done     <= done_d;
            busy     <= (state_d != S_IDLE);
            err      <= err_d;
            err_code <= err_code_d;
            if (state_d != state) begin
                wdog <= WD_LOAD;
            end else if (wd_dec) begin
                wdog <= wdog - WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regime_scheduler.sv
// Bench for regime_scheduler: reactive controller model, vector table and corner sequences.
module tb_regime_scheduler;
    import regime_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;
    localparam int ACT_DLY = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [CNT_W-1:0] cnt_len;
    logic             err_clr;
    logic [1:0]       regime = 2'd0;
    logic             active = 1'b0;
    logic [1:0]       on;
    logic             start;
    logic [2:0]       gnt;
    logic [2:0]       done;
    logic             busy;
    logic             err;
    logic [1:0]       err_code;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp_gnt_q[$];

    typedef struct {
        logic [2:0]       req;
        logic [CNT_W-1:0] len;
        logic [2:0]       exp_gnt;
        int               exp_start;
    } vec_t;

    vec_t tv[8];

    regime_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cnt_len  (cnt_len),
        .err_clr  (err_clr),
        .regime   (regime),
        .active   (active),
        .on       (on),
        .start    (start),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Controller model: echoes on into regime, raises active after ACT_DLY start cycles,
    // ends CNT when start falls, ends UPDATE after two cycles.
    logic no_echo_upd = 1'b0;
    int   m_cnt = 0;
    logic saw_start = 1'b0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            regime = CODE_OFF;
            active = 1'b0;
            m_cnt = 0;
            saw_start = 1'b0;
        end else begin
            case (regime)
                CODE_OFF: begin
                    if (on != CODE_OFF && !(no_echo_upd && on == CODE_UPDATE)) begin
                        regime = on;
                        m_cnt = 0;
                        saw_start = 1'b0;
                    end
                end
                CODE_ELIST: begin
                    if (!active) begin
                        if (start) begin
                            m_cnt++;
                            if (m_cnt == ACT_DLY) begin
                                active = 1'b1;
                                m_cnt = 0;
                            end
                        end
                    end else begin
                        m_cnt++;
                        if (m_cnt == 3) begin
                            active = 1'b0;
                            regime = CODE_OFF;
                            m_cnt = 0;
                        end
                    end
                end
                CODE_CNT: begin
                    if (start) begin
                        saw_start = 1'b1;
                    end else if (saw_start) begin
                        regime = CODE_OFF;
                        saw_start = 1'b0;
                    end
                end
                default: begin
                    m_cnt++;
                    if (m_cnt == 2) begin
                        regime = CODE_OFF;
                        m_cnt = 0;
                    end
                end
            endcase
        end
    end

    // Scoreboard monitor: grant order, one-hot grant, done order.
    logic [2:0] prev_gnt = 3'b000;
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            prev_gnt = 3'b000;
        end else begin
            if (gnt != 3'b000) check("gnt_onehot", $countones(gnt), 1);
            if (gnt != 3'b000 && prev_gnt == 3'b000) begin
                if (exp_gnt_q.size() == 0) begin
                    check("unexpected_gnt", gnt, 3'b000);
                end else begin
                    e = exp_gnt_q.pop_front();
                    check("gnt_order", gnt, e);
                end
            end
            if (done != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 3'b000);
                end else begin
                    e = exp_q.pop_front();
                    check("done_order", done, e);
                end
            end
            prev_gnt = gnt;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string nm, input logic [2:0] eg);
        int n;
        n = 0;
        while (gnt == 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_gnt"}, gnt, eg);
    endtask

    task automatic run_txn(input logic [2:0] r, input logic [CNT_W-1:0] l,
                           input logic [2:0] eg, input int es, input string nm);
        int n;
        int st;
        logic [1:0] ecode;
        ecode = (eg == 3'b001) ? CODE_ELIST : (eg == 3'b010) ? CODE_CNT : CODE_UPDATE;
        exp_gnt_q.push_back(eg);
        exp_q.push_back(eg);
        @(negedge clk);
        req = r;
        cnt_len = l;
        @(negedge clk);
        wait_gnt(nm, eg);
        check({nm, "_on"}, on, ecode);
        check({nm, "_busy"}, busy, 1'b1);
        req = 3'b000;
        st = 0;
        n = 0;
        while (done == 3'b000 && n < 300) begin
            if (start) st++;
            @(negedge clk);
            n++;
        end
        check({nm, "_start_cycles"}, st, es);
        check({nm, "_done"}, done, eg);
        check({nm, "_busy_at_done"}, busy, 1'b0);
        @(negedge clk);
        check({nm, "_done_pulse"}, done, 3'b000);
    endtask

    initial begin
        int n;
        int nd;
        int total;

        rst = 1'b1;
        req = 3'b000;
        cnt_len = '0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_on", on, 2'd0);
        check("rst_start", start, 1'b0);
        check("rst_gnt", gnt, 3'b000);
        check("rst_done", done, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        rst = 1'b0;

        tv[0] = '{3'b001, 8'd0, 3'b001, ACT_DLY};
        tv[1] = '{3'b010, 8'd5, 3'b010, 5};
        tv[2] = '{3'b010, 8'd0, 3'b010, 1};
        tv[3] = '{3'b100, 8'd9, 3'b100, 0};
        tv[4] = '{3'b010, 8'd1, 3'b010, 1};
        tv[5] = '{3'b011, 8'd3, 3'b001, ACT_DLY};
        tv[6] = '{3'b110, 8'd7, 3'b010, 7};
        tv[7] = '{3'b101, 8'd4, 3'b100, 0};
        for (int i = 0; i < 8; i++) begin
            run_txn(tv[i].req, tv[i].len, tv[i].exp_gnt, tv[i].exp_start, $sformatf("vec%0d", i));
        end

        // UPDATE with its request dropped right after grant still completes.
        run_txn(3'b100, 8'd0, 3'b100, 0, "upd_drop");

        // Round-robin with all three held from a fresh pointer.
        apply_reset();
        exp_gnt_q.push_back(3'b001); exp_q.push_back(3'b001);
        exp_gnt_q.push_back(3'b010); exp_q.push_back(3'b010);
        exp_gnt_q.push_back(3'b100); exp_q.push_back(3'b100);
        exp_gnt_q.push_back(3'b001); exp_q.push_back(3'b001);
        cnt_len = 8'd2;
        req = 3'b111;
        n = 0;
        nd = 0;
        while (nd < 4 && n < 1000) begin
            @(negedge clk);
            n++;
            if (done != 3'b000) nd++;
        end
        req = 3'b000;
        check("rr_done_count", nd, 4);
        repeat (3) @(negedge clk);
        check("rr_idle_gnt", gnt, 3'b000);
        check("rr_idle_busy", busy, 1'b0);

        // UPDATE never echoed: watchdog abort.
        no_echo_upd = 1'b1;
        exp_gnt_q.push_back(3'b100);
        req = 3'b100;
        @(negedge clk);
        wait_gnt("wd", 3'b100);
        req = 3'b000;
        repeat (TIMEOUT - 6) @(negedge clk);
        check("wd_err_early", err, 1'b0);
        check("wd_gnt_held", gnt, 3'b100);
        check("wd_on_held", on, CODE_UPDATE);
        n = 0;
        while (!err && n < 20) begin
            @(negedge clk);
            n++;
        end
        total = TIMEOUT - 6 + n;
        check("wd_latency_window", (total >= TIMEOUT - 2) && (total <= TIMEOUT + 2), 1'b1);
        check("wd_err", err, 1'b1);
        check("wd_err_code", err_code, CODE_UPDATE);
        check("wd_gnt", gnt, 3'b000);
        check("wd_on", on, CODE_OFF);
        check("wd_start", start, 1'b0);
        check("wd_done", done, 3'b000);
        repeat (5) @(negedge clk);
        check("wd_err_sticky", err, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("wd_err_clr", err, 1'b0);
        check("wd_err_code_clr", err_code, 2'd0);
        no_echo_upd = 1'b0;

        // Async reset in the middle of a CNT hold.
        exp_gnt_q.push_back(3'b010);
        cnt_len = 8'd40;
        req = 3'b010;
        @(negedge clk);
        wait_gnt("rst_cnt", 3'b010);
        req = 3'b000;
        n = 0;
        while (!start && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("rst_cnt_start_hold", start, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_on", on, 2'd0);
        check("rst_async_start", start, 1'b0);
        check("rst_async_gnt", gnt, 3'b000);
        check("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(3'b111, 8'd0, 3'b001, ACT_DLY, "post_rst");

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("exp_gnt_q_empty", exp_gnt_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
